// File: rtl/tqvp_reg_arbiter_if.sv
// Requester-side register bus: a valid/ready request channel plus a one-cycle
// completion pulse carrying read data back to the requester.
interface tqvp_reg_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              valid;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    // The requester drives the request fields and consumes the response.
    modport master (
        output valid, write, addr, wdata,
        input  ready, rvalid, rdata
    );

    // The arbiter consumes the request fields and drives the response.
    modport slave (
        input  valid, write, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/tqvp_reg_arbiter.sv
// Two-requester round-robin arbiter in front of a single peripheral register
// port; each accepted request runs IDLE -> ACCESS -> RESP, one cycle per state.
module tqvp_reg_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    tqvp_reg_arbiter_if.slave req0,
    tqvp_reg_arbiter_if.slave req1,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              data_write,
    input  logic [DATA_W-1:0] data_out
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e            state_q,  state_d;
    // The last-served requester is also the owner of the in-flight transaction.
    logic              last_q,   last_d;
    logic              wr_q,     wr_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] resp;

    // On a tie the requester that was not served last wins.
    assign grant  = (req0.valid && req1.valid) ? ~last_q : req1.valid;
    assign accept = (state_q == S_IDLE) && (req0.valid || req1.valid) && !rst;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
        state_d  = state_q;
        last_d   = last_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        resp     = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ACCESS;
                    last_d  = grant;
                    wr_d    = grant ? req1.write : req0.write;
                    addr_d  = grant ? req1.addr  : req0.addr;
                    wdata_d = grant ? req1.wdata : req0.wdata;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                resp    = wr_q ? '0 : data_out;
                if (last_q) rdata1_d = resp;
                else        rdata0_d = resp;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // The latched request doubles as the peripheral drive, holding between accesses.
    assign address    = addr_q;
    assign data_in    = wdata_q;
    assign data_write = (state_q == S_ACCESS) && wr_q;

    assign req0.ready  = accept && !grant;
    assign req1.ready  = accept &&  grant;
    assign req0.rvalid = (state_q == S_RESP) && !last_q;
    assign req1.rvalid = (state_q == S_RESP) &&  last_q;
    assign req0.rdata  = rdata0_q;
    assign req1.rdata  = rdata1_q;
endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// Directed bench for tqvp_reg_arbiter with a 16-entry register file as the
// peripheral; inputs change and outputs are checked on the falling edge.
module tb_tqvp_reg_arbiter;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              data_write;
    logic [DATA_W-1:0] data_out;

    logic [DATA_W-1:0] mem [16];
    int                wr_cnt = 0;
    int                n_checks = 0;
    int                n_fail = 0;

    tqvp_reg_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req0_if ();
    tqvp_reg_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req1_if ();

    tqvp_reg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0_if),
        .req1       (req1_if),
        .address    (address),
        .data_in    (data_in),
        .data_write (data_write),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    // Peripheral: combinational read, write on the strobe.
    assign data_out = mem[address];
    always @(posedge clk) begin
        if (data_write) begin
            mem[address] <= data_in;
            wr_cnt       <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[5] = 8'hA7;
        mem[3] = 8'h11;
        mem[4] = 8'h22;
        rst = 1'b1;
        req0_if.valid = 1'b1; req0_if.write = 1'b0; req0_if.addr = 4'h0; req0_if.wdata = 8'h00;
        req1_if.valid = 1'b0; req1_if.write = 1'b0; req1_if.addr = 4'h0; req1_if.wdata = 8'h00;

        // Reset state, with a request pending that must not be accepted.
        cyc(); cyc(); #1;
        check("rst_ready0", req0_if.ready, 0);
        check("rst_address", address, 0);
        check("rst_data_in", data_in, 0);
        check("rst_data_write", data_write, 0);
        check("rst_rvalid0", req0_if.rvalid, 0);
        check("rst_rvalid1", req1_if.rvalid, 0);
        check("rst_rdata0", req0_if.rdata, 0);
        check("rst_rdata1", req1_if.rdata, 0);
        req0_if.valid = 1'b0;
        rst = 1'b0;

        // Single read: req0 reads 0x5.
        cyc();
        req0_if.valid = 1'b1; req0_if.write = 1'b0; req0_if.addr = 4'h5; #1;
        check("rd_ready0", req0_if.ready, 1);
        check("rd_ready1", req1_if.ready, 0);
        cyc(); req0_if.valid = 1'b0; #1;
        check("rd_address", address, 4'h5);
        check("rd_wr_access", data_write, 0);
        check("rd_rvalid_early", req0_if.rvalid, 0);
        cyc(); #1;
        check("rd_rvalid0", req0_if.rvalid, 1);
        check("rd_rdata0", req0_if.rdata, 8'hA7);
        check("rd_wr_resp", data_write, 0);
        cyc(); #1;
        check("rd_rvalid_drop", req0_if.rvalid, 0);
        check("rd_rdata_hold", req0_if.rdata, 8'hA7);

        // Single write: req1 writes 0x3C to 0x2.
        req1_if.valid = 1'b1; req1_if.write = 1'b1; req1_if.addr = 4'h2; req1_if.wdata = 8'h3C; #1;
        check("wr_ready1", req1_if.ready, 1);
        cyc(); req1_if.valid = 1'b0; #1;
        check("wr_strobe", data_write, 1);
        check("wr_address", address, 4'h2);
        check("wr_data_in", data_in, 8'h3C);
        cyc(); #1;
        check("wr_strobe_off", data_write, 0);
        check("wr_rvalid1", req1_if.rvalid, 1);
        check("wr_rvalid0", req0_if.rvalid, 0);
        check("wr_rdata1", req1_if.rdata, 0);
        check("wr_rdata0_kept", req0_if.rdata, 8'hA7);
        check("wr_address_hold", address, 4'h2);
        check("wr_data_in_hold", data_in, 8'h3C);
        check("wr_mem", mem[2], 8'h3C);
        cyc(); #1;
        check("wr_rvalid1_drop", req1_if.rvalid, 0);

        // Contention: both read continuously, grants alternate starting with req0.
        req0_if.valid = 1'b1; req0_if.write = 1'b0; req0_if.addr = 4'h3;
        req1_if.valid = 1'b1; req1_if.write = 1'b0; req1_if.addr = 4'h4;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("ct_ready0", req0_if.ready, (k % 2 == 0) ? 1 : 0);
            check("ct_ready1", req1_if.ready, (k % 2 == 1) ? 1 : 0);
            cyc(); #1;
            check("ct_busy1_ready", req0_if.ready | req1_if.ready, 0);
            cyc(); #1;
            check("ct_busy2_ready", req0_if.ready | req1_if.ready, 0);
            if (k % 2 == 0) begin
                check("ct_rvalid0", req0_if.rvalid, 1);
                check("ct_rdata0", req0_if.rdata, 8'h11);
            end else begin
                check("ct_rvalid1", req1_if.rvalid, 1);
                check("ct_rdata1", req1_if.rdata, 8'h22);
            end
            cyc();
        end
        req0_if.valid = 1'b0; req1_if.valid = 1'b0;

        // Reset in the ACCESS cycle of a req0 write.
        req0_if.valid = 1'b1; req0_if.write = 1'b1; req0_if.addr = 4'h7; req0_if.wdata = 8'h99; #1;
        check("ra_ready0", req0_if.ready, 1);
        cyc(); req0_if.valid = 1'b0; #1;
        check("ra_strobe", data_write, 1);
        rst = 1'b1;
        cyc(); #1;
        check("ra_strobe_off", data_write, 0);
        check("ra_rvalid0", req0_if.rvalid, 0);
        check("ra_address", address, 0);
        check("ra_data_in", data_in, 0);
        check("ra_rdata0", req0_if.rdata, 0);
        check("ra_rdata1", req1_if.rdata, 0);
        rst = 1'b0;
        cyc(); #1;
        check("ra_no_rvalid0", req0_if.rvalid, 0);
        check("ra_no_rvalid1", req1_if.rvalid, 0);
        req0_if.valid = 1'b1; req0_if.write = 1'b0; req0_if.addr = 4'h5;
        req1_if.valid = 1'b1; req1_if.write = 1'b0; req1_if.addr = 4'h2; #1;
        check("ra_tie_ready0", req0_if.ready, 1);
        check("ra_tie_ready1", req1_if.ready, 0);
        cyc(); req0_if.valid = 1'b0;
        cyc(); #1;
        check("ra_tie_rvalid0", req0_if.rvalid, 1);
        check("ra_tie_rdata0", req0_if.rdata, 8'hA7);
        check("ra_tie_rvalid1", req1_if.rvalid, 0);
        cyc(); #1;
        check("ra_next_ready1", req1_if.ready, 1);
        cyc(); req1_if.valid = 1'b0;
        cyc(); #1;
        check("ra_next_rvalid1", req1_if.rvalid, 1);
        check("ra_next_rdata1", req1_if.rdata, 8'h3C);
        cyc();

        // Hold/drop: req0 changes addr after acceptance; req1 pulses valid while busy.
        req0_if.valid = 1'b1; req0_if.write = 1'b0; req0_if.addr = 4'h3; #1;
        check("hd_ready0", req0_if.ready, 1);
        cyc();
        req0_if.valid = 1'b0; req0_if.addr = 4'h4;
        req1_if.valid = 1'b1; req1_if.write = 1'b1; req1_if.addr = 4'h9; req1_if.wdata = 8'hEE; #1;
        check("hd_address", address, 4'h3);
        check("hd_ready1_busy", req1_if.ready, 0);
        cyc(); req1_if.valid = 1'b0; #1;
        check("hd_rvalid0", req0_if.rvalid, 1);
        check("hd_rdata0", req0_if.rdata, 8'h11);
        cyc(); #1;
        check("hd_ready1_idle", req1_if.ready, 0);
        cyc(); #1;
        check("hd_no_access", data_write, 0);
        check("hd_no_rvalid1", req1_if.rvalid, 0);
        check("hd_mem9", mem[9], 0);

        // Write then read back the same register through the peripheral.
        req0_if.valid = 1'b1; req0_if.write = 1'b1; req0_if.addr = 4'h1; req0_if.wdata = 8'h55; #1;
        check("mx_ready0", req0_if.ready, 1);
        cyc(); req0_if.valid = 1'b0; #1;
        check("mx_strobe", data_write, 1);
        check("mx_address", address, 4'h1);
        check("mx_data_in", data_in, 8'h55);
        cyc(); #1;
        check("mx_rvalid0", req0_if.rvalid, 1);
        check("mx_rdata0", req0_if.rdata, 0);
        cyc();
        req1_if.valid = 1'b1; req1_if.write = 1'b0; req1_if.addr = 4'h1; #1;
        check("mx_ready1", req1_if.ready, 1);
        cyc(); req1_if.valid = 1'b0;
        cyc(); #1;
        check("mx_rvalid1", req1_if.rvalid, 1);
        check("mx_rdata1", req1_if.rdata, 8'h55);
        cyc(); #1;
        check("total_writes", wr_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
